// File: rtl/e05_pkg.sv
// Shared types and widths for the E05 input stepper.
package e05_pkg;

  localparam int unsigned CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

endpackage

// File: rtl/e05_debounce.sv
// Two-flop synchronizer plus debounce FSM; emits one press strobe per accepted press.
module e05_debounce
  import e05_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Next state: the counter holds how many consecutive samples agree with the pending level.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/e05_input_stepper.sv
// Drives the E05 a/b/c inputs: debounced manual stepping or prescaled auto-run.
module e05_input_stepper
  import e05_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned AUTO_DIV        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_step,
  input  logic              btn_mode,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic [CODE_W-1:0] code,
  output logic              auto_mode,
  output logic              step_pulse
);

  localparam int unsigned PRE_W = $clog2(AUTO_DIV);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);

  logic              step_press;
  logic              mode_press;
  logic              do_step;
  logic [CODE_W-1:0] code_q, code_d;
  logic              auto_q, auto_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              step_pulse_q, step_pulse_d;

  e05_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_step),
    .press (step_press)
  );

  e05_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .press (mode_press)
  );

  // Mode toggle has priority over any step; prescaler only runs in auto mode.
  always_comb begin
    auto_d  = auto_q;
    pre_d   = pre_q;
    do_step = 1'b0;
    if (mode_press) begin
      auto_d = ~auto_q;
      pre_d  = '0;
    end else if (auto_q) begin
      if (pre_q == PRE_LAST) begin
        pre_d   = '0;
        do_step = 1'b1;
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end else begin
      pre_d   = '0;
      do_step = step_press;
    end
    code_d       = do_step ? code_q + CODE_W'(1) : code_q;
    step_pulse_d = do_step;
  end

  // Mode, prescaler, code and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q       <= '0;
      auto_q       <= 1'b0;
      pre_q        <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      code_q       <= code_d;
      auto_q       <= auto_d;
      pre_q        <= pre_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign code       = code_q;
  assign a          = code_q[2];
  assign b          = code_q[1];
  assign c          = code_q[0];
  assign auto_mode  = auto_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_e05_input_stepper.sv
// Self-checking bench for e05_input_stepper against a sample-history reference model.
module tb_e05_input_stepper;

  localparam int unsigned DEB = 4;
  localparam int unsigned DIV = 8;

  logic       clk;
  logic       rst_n;
  logic       btn_step;
  logic       btn_mode;
  logic       a, b, c;
  logic [2:0] code;
  logic       auto_mode;
  logic       step_pulse;

  e05_input_stepper #(.DEBOUNCE_CYCLES(DEB), .AUTO_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_step   (btn_step),
    .btn_mode   (btn_mode),
    .a          (a),
    .b          (b),
    .c          (c),
    .code       (code),
    .auto_mode  (auto_mode),
    .step_pulse (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int pulses = 0;

  // Reference model: raw samples per edge, accepted levels, pending strobes, outputs.
  int          cyc = 0;
  int          since = 0;
  logic [15:0] sh_s, sh_m;
  logic        acc_s, acc_m, pr_s, pr_m;
  int          m_code;
  logic        m_auto, m_pulse;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // True when the last DEB synchronized samples (raw sample two edges back) all equal lvl.
  function automatic logic all_lvl(input logic [15:0] sh, input logic lvl);
    for (int k = 2; k < int'(DEB) + 2; k++) if (sh[k] !== lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    sh_s = '0; sh_m = '0;
    acc_s = 0; acc_m = 0; pr_s = 0; pr_m = 0;
    m_code = 0; m_auto = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    logic stp;
    cyc++;
    stp = 1'b0;
    if (pr_m) begin
      m_auto = !m_auto;
      since  = cyc;
    end else if (m_auto) begin
      if ((cyc - since) % int'(DIV) == 0) stp = 1'b1;
    end else if (pr_s) begin
      stp = 1'b1;
    end
    m_pulse = stp;
    if (stp) m_code = (m_code + 1) % 8;
    sh_s = {sh_s[14:0], btn_step};
    sh_m = {sh_m[14:0], btn_mode};
    pr_s = 1'b0;
    if (!acc_s && all_lvl(sh_s, 1'b1)) begin acc_s = 1; pr_s = 1; end
    else if (acc_s && all_lvl(sh_s, 1'b0)) acc_s = 0;
    pr_m = 1'b0;
    if (!acc_m && all_lvl(sh_m, 1'b1)) begin acc_m = 1; pr_m = 1; end
    else if (acc_m && all_lvl(sh_m, 1'b0)) acc_m = 0;
  endtask

  // One clock: advance the model at the rising edge, compare outputs at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
    if (rst_n) begin
      chk("code", 32'(code), 32'(m_code));
      chk("abc", 32'({a, b, c}), 32'(m_code));
      chk("auto_mode", 32'(auto_mode), 32'(m_auto));
      chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
      if (step_pulse) pulses++;
    end
  endtask

  task automatic press_btn(input bit is_mode, input int hi, input int lo);
    if (is_mode) btn_mode = 1'b1; else btn_step = 1'b1;
    repeat (hi) tick();
    if (is_mode) btn_mode = 1'b0; else btn_step = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_reset(input int hold);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_auto", 32'(auto_mode), 32'd0);
    chk("rst_pulse", 32'(step_pulse), 32'd0);
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int         p0, lat, c_before, waited;
  logic [6:0] bounce_pat;

  initial begin
    btn_step = 1'b0;
    btn_mode = 1'b0;
    rst_n    = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Clean manual steps with latency measurement.
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      btn_step = 1'b1;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (lat < 0 && step_pulse) lat = k - 1;
      end
      chk("press_latency", 32'(lat), 32'(DEB + 2));
      btn_step = 1'b0;
      repeat (10) tick();
      chk("manual_code", 32'(code), 32'((i + 1) % 8));
    end
    chk("manual_pulses", 32'(pulses - p0), 32'd8);

    // Bounce rejection, then a valid 10-cycle hold.
    p0 = pulses;
    bounce_pat = 7'b1110101;
    for (int k = 0; k < 7; k++) begin
      btn_step = bounce_pat[k];
      tick();
    end
    btn_step = 1'b0;
    repeat (12) tick();
    chk("bounce_steps", 32'(pulses - p0), 32'd0);
    press_btn(1'b0, 10, 12);
    chk("bounce_then_hold", 32'(pulses - p0), 32'd1);

    // Auto mode with step presses ignored.
    press_btn(1'b1, 10, 10);
    chk("auto_on", 32'(auto_mode), 32'd1);
    p0 = pulses;
    for (int j = 0; j < 4; j++) press_btn(1'b0, 8, 8);
    chk("auto_window_steps", 32'(pulses - p0), 32'd8);

    // Reset mid-prescale while auto-running with code 5.
    waited = 0;
    while (m_code != 5 && waited < 64) begin tick(); waited++; end
    chk("reach_code5", 32'(code), 32'd5);
    repeat (3) tick();
    do_reset(2);
    p0 = pulses;
    repeat (20) tick();
    chk("post_reset_idle", 32'(pulses - p0), 32'd0);

    // Mode press landing exactly on a prescaler terminal count.
    press_btn(1'b1, 10, 10);
    for (int g = 0; g < 16 && ((cyc + 7 - since) % int'(DIV)) != 0; g++) tick();
    btn_mode = 1'b1;
    repeat (6) tick();
    c_before = m_code;
    tick();
    chk("collide_auto", 32'(auto_mode), 32'd0);
    chk("collide_pulse", 32'(step_pulse), 32'd0);
    chk("collide_code", 32'(code), 32'(c_before));
    repeat (3) tick();
    btn_mode = 1'b0;
    repeat (12) tick();

    // Long hold gives one step; a fresh press gives one more.
    p0 = pulses;
    btn_step = 1'b1;
    repeat (200) tick();
    btn_step = 1'b0;
    repeat (12) tick();
    chk("long_hold", 32'(pulses - p0), 32'd1);
    press_btn(1'b0, 10, 10);
    chk("long_hold_repress", 32'(pulses - p0), 32'd2);

    // Randomized button activity.
    repeat (60) begin
      btn_step = 1'($urandom_range(0, 1));
      btn_mode = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) tick();
    end
    btn_step = 1'b0;
    btn_mode = 1'b0;
    repeat (20) tick();

    // Button already held when reset releases.
    btn_step = 1'b1;
    do_reset(2);
    p0 = pulses;
    repeat (12) tick();
    chk("held_through_reset", 32'(pulses - p0), 32'd1);
    btn_step = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/e05_input_stepper.md
# e05_input_stepper

Upstream stimulus stage for the E05 3-input combinational function block: produces its `a`, `b`, `c` inputs from two raw board pushbuttons. A debounced step button advances a 3-bit code 0→7 with wrap, and a debounced mode button toggles an auto-run mode that advances the code at a fixed prescaled rate. Bit mapping matches the E05 bench: `a` = code[2] (MSB), `b` = code[1], `c` = code[0] (LSB).

## Interface
- `DEBOUNCE_CYCLES`, 4, consecutive stable synchronized samples required to accept a press or release; legal range 2..65535.
- `AUTO_DIV`, 8, clock cycles between auto-mode steps; legal range 2..2^24.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; release is synchronous to `clk` at the board level.
- `btn_step`  in  1  raw step button, asynchronous to `clk`, active-high, bouncy.
- `btn_mode`  in  1  raw mode button, asynchronous to `clk`, active-high, bouncy.
- `a`  out  1  code[2].
- `b`  out  1  code[1].
- `c`  out  1  code[0].
- `code`  out  3  current code; same register as `a`/`b`/`c`.
- `auto_mode`  out  1  1 = auto-run active; 0 = manual stepping.
- `step_pulse`  out  1  one-cycle strobe, high in the cycle during which `code` is incremented.

## Operation
- Each button passes through a 2-flop synchronizer, then a debounce FSM.
- Debounce FSM states: IDLE (accepted low), PRESS_WAIT, HELD (accepted high), RELEASE_WAIT.
  - IDLE → PRESS_WAIT on a synchronized high; the counter loads 1.
  - PRESS_WAIT: a synchronized low returns to IDLE. When the counter reaches DEBOUNCE_CYCLES with the input still high, go to HELD and emit a one-cycle `press` strobe.
  - HELD → RELEASE_WAIT on a synchronized low; the counter loads 1.
  - RELEASE_WAIT: a synchronized high returns to HELD. DEBOUNCE_CYCLES consecutive lows go to IDLE.
  - Exactly one `press` per accepted press. Holding the button never repeats.
- Mode button `press`:
  - toggles `auto_mode`;
  - clears the prescaler to 0;
  - causes no code step in that cycle.
- Manual mode (`auto_mode`=0): a step `press` increments `code` modulo 8. The prescaler is held at 0.
- Auto mode (`auto_mode`=1):
  - The prescaler counts 0..AUTO_DIV-1.
  - At terminal count, `code` increments modulo 8 and the prescaler wraps to 0.
  - Step-button presses are ignored. The step debouncer keeps tracking, so no stale press fires on return to manual.
- Simultaneous events:
  - mode `press` in the same cycle as an auto terminal count → the mode toggle wins and no step occurs;
  - mode `press` together with a step `press` in manual mode → the toggle wins and the step is dropped.
- Wrap: 7 → 0 with `step_pulse` asserted, identical to any other step.
- Reset, including mid-debounce or mid-prescale:
  - `code`=0 (`a`=`b`=`c`=0), `auto_mode`=0, `step_pulse`=0;
  - synchronizers 0, both FSMs IDLE, all counters 0.
  - A button already held at reset release is accepted after the normal latency.

## Timing
- Press latency: `btn_step` rises before edge E0 and stays high.
  - The synchronized value is high after edge E0+2.
  - The `press` strobe is registered at edge E0+DEBOUNCE_CYCLES+1.
  - `code` and `step_pulse` update at edge E0+DEBOUNCE_CYCLES+2. For the default of 4, that is 6 edges.
- Bounce rejection: a high pulse shorter than DEBOUNCE_CYCLES synchronized samples produces no step.
- Auto rate: the first auto step occurs AUTO_DIV cycles after the edge that sets `auto_mode`. After that, one step every AUTO_DIV cycles.
- `step_pulse` is exactly 1 cycle wide and is registered. `code` is registered and glitch-free.

## Structure
- Package `e05_pkg`:
  - `CODE_W` = 3;
  - debounce state enum `deb_state_t` {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
- Sub-module `e05_debounce`: synchronizer, FSM and counter, parameterised by DEBOUNCE_CYCLES, with output `press`. Instantiated twice.
- Top level holds the mode flag, prescaler and code counter.

## Test plan
All with DEBOUNCE_CYCLES=4, AUTO_DIV=8.
- Reset: assert `rst_n`=0 mid-count with `code`=5 and `auto_mode`=1 → `code`=0, `auto_mode`=0, `step_pulse`=0 immediately; no step in the 20 cycles after release with buttons low.
- Clean manual steps: 8 clean presses of `btn_step` (10-cycle high, 10-cycle low) → `code` goes 1..7 then 0; 8 `step_pulse` strobes; each `code` change 6 edges after the press starts.
- Bounce rejection: `btn_step` toggled 1,0,1,0 each cycle, then held high 3 cycles → no step. Held high 10 cycles → exactly one step.
- Auto mode: press `btn_mode` → `auto_mode`=1. `code` increments every 8 cycles (0→1→…→7→0). Step presses during auto → no extra steps.
- Auto exit collision: align a mode `press` with a prescaler terminal count → `auto_mode`=0, `code` unchanged, no `step_pulse`.
- Long hold: `btn_step` held 200 cycles → exactly one step. Release, then re-press → one more step.
